// File: rtl/loop_event_pkg.sv
// Shared types for the loop event recorder: record kinds, the buffered
// record layout, FSM states and a saturating counter helper.
package loop_event_pkg;

  localparam int REC_TS_W  = 32;
  localparam int REC_CNT_W = 16;
  localparam int REC_DEPTH = 8;

  typedef enum logic [1:0] {
    REC_START  = 2'd0,
    REC_DONE   = 2'd1,
    REC_STALL  = 2'd2,
    REC_FINISH = 2'd3
  } rec_kind_e;

  typedef struct packed {
    rec_kind_e              kind;
    logic [REC_TS_W-1:0]    ts;
    logic [REC_CNT_W-1:0]   data;
  } rec_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACTIVE    = 2'd1,
    ST_WAIT_CONT = 2'd2,
    ST_STOPPED   = 2'd3
  } fsm_state_e;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [REC_CNT_W-1:0] sat_inc(input logic [REC_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/event_rec_fifo.sv
// Small synchronous FIFO of event records. The head entry is read straight
// out of the storage registers, so a pushed record is visible the cycle after
// the push. Drop accounting for pushes into a full FIFO lives in the caller.
module event_rec_fifo
  import loop_event_pkg::*;
#(
  parameter int DEPTH = REC_DEPTH
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  rec_t push_data,
  input  logic pop,
  output rec_t head,
  output logic empty,
  output logic full
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates "full" from "empty" once the pointers wrap.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  rec_t        mem_q [DEPTH];
  rec_t        mem_d [DEPTH];
  logic        wr_en;
  logic        rd_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // Next-state for storage and pointers; a write into a full FIFO reuses the
  // slot that the simultaneous pop is releasing.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Register storage and pointers; reset clears contents so the outputs read 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/loop_event_recorder.sv
// Event front-end for dataflow profiling: turns one kernel's block-level
// handshake and loop iteration strobes into timestamped START/DONE/STALL/
// FINISH records and buffers them for a valid/ready consumer.
module loop_event_recorder
  import loop_event_pkg::*;
#(
  parameter int TS_W  = REC_TS_W,
  parameter int CNT_W = REC_CNT_W,
  parameter int DEPTH = REC_DEPTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             iter_end,
  input  logic             finish,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [1:0]       rec_kind,
  output logic [TS_W-1:0]  rec_ts,
  output logic [CNT_W-1:0] rec_data,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_cnt
);

  fsm_state_e       state_q, state_d;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [CNT_W-1:0] txn_idx_q, txn_idx_d;
  logic [CNT_W-1:0] iter_cnt_q, iter_cnt_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             finish_pend_q, finish_pend_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic             push;
  rec_t             push_rec;
  logic [CNT_W-1:0] iter_next;
  logic             pop;
  logic             drop;
  logic             fifo_empty;
  logic             fifo_full;
  rec_t             head;

  // ap_ready carries no information the records need.
  logic             unused_ap_ready;
  assign unused_ap_ready = ap_ready;

  assign rec_valid = ~fifo_empty;
  assign pop       = rec_valid & rec_ready;
  assign drop      = push & fifo_full & ~pop;
  assign rec_kind  = head.kind;
  assign rec_ts    = head.ts;
  assign rec_data  = head.data;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

  // Handshake tracking and record generation; at most one push per cycle,
  // with a pending FINISH waiting for a cycle that has no other record.
  always_comb begin
    state_d       = state_q;
    ts_d          = ts_q + 1'b1;
    txn_idx_d     = txn_idx_q;
    iter_cnt_d    = iter_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    finish_pend_d = finish_pend_q;
    overflow_d    = overflow_q | drop;
    drop_cnt_d    = drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
    push          = 1'b0;
    push_rec      = '{kind: REC_START, ts: ts_q, data: '0};
    iter_next     = iter_end ? sat_inc(iter_cnt_q) : iter_cnt_q;

    if (state_q != ST_STOPPED && finish) begin
      finish_pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (ap_start) begin
          push          = 1'b1;
          push_rec.kind = REC_START;
          push_rec.data = txn_idx_q;
          txn_idx_d     = sat_inc(txn_idx_q);
          iter_cnt_d    = '0;
          state_d       = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        iter_cnt_d = iter_next;
        if (ap_done) begin
          push          = 1'b1;
          push_rec.kind = REC_DONE;
          push_rec.data = iter_next;
          if (ap_continue) begin
            state_d = ST_IDLE;
          end else begin
            wait_cnt_d = '0;
            state_d    = ST_WAIT_CONT;
          end
        end
      end
      ST_WAIT_CONT: begin
        if (ap_continue) begin
          push          = 1'b1;
          push_rec.kind = REC_STALL;
          push_rec.data = sat_inc(wait_cnt_q);
          state_d       = ST_IDLE;
        end else begin
          wait_cnt_d = sat_inc(wait_cnt_q);
        end
      end
      default: begin
      end
    endcase

    if (state_q != ST_STOPPED && finish_pend_q && !push) begin
      push          = 1'b1;
      push_rec.kind = REC_FINISH;
      push_rec.data = txn_idx_q;
      state_d       = ST_STOPPED;
    end
  end

  // State, counters and sticky overflow status.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      ts_q          <= '0;
      txn_idx_q     <= '0;
      iter_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      finish_pend_q <= 1'b0;
      overflow_q    <= 1'b0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      ts_q          <= ts_d;
      txn_idx_q     <= txn_idx_d;
      iter_cnt_q    <= iter_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      finish_pend_q <= finish_pend_d;
      overflow_q    <= overflow_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  event_rec_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_rec),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_loop_event_recorder.sv
// Directed bench for loop_event_recorder: single transaction, backpressured
// continue, finish arbitration, overflow, full-with-pop and mid-run reset.
module tb_loop_event_recorder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ap_start = 1'b0;
  logic        ap_ready = 1'b0;
  logic        ap_done = 1'b0;
  logic        ap_continue = 1'b0;
  logic        iter_end = 1'b0;
  logic        finish = 1'b0;
  logic        rec_valid;
  logic        rec_ready = 1'b0;
  logic [1:0]  rec_kind;
  logic [31:0] rec_ts;
  logic [15:0] rec_data;
  logic        overflow;
  logic [15:0] drop_cnt;

  int checks = 0;
  int failures = 0;
  int bts;
  int done_ts;

  localparam logic [1:0] K_START  = 2'd0;
  localparam logic [1:0] K_DONE   = 2'd1;
  localparam logic [1:0] K_STALL  = 2'd2;
  localparam logic [1:0] K_FINISH = 2'd3;

  loop_event_recorder dut (
    .clock       (clock),
    .reset       (reset),
    .ap_start    (ap_start),
    .ap_ready    (ap_ready),
    .ap_done     (ap_done),
    .ap_continue (ap_continue),
    .iter_end    (iter_end),
    .finish      (finish),
    .rec_valid   (rec_valid),
    .rec_ready   (rec_ready),
    .rec_kind    (rec_kind),
    .rec_ts      (rec_ts),
    .rec_data    (rec_data),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt)
  );

  always #5 clock = ~clock;

  // Bench cycle counter: equals the timestamp of the cycle currently open.
  always @(posedge clock) begin
    if (reset) bts <= 0;
    else       bts <= bts + 1;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the head record, then pops it with a one-cycle rec_ready pulse.
  task automatic check_record(input string tag, input logic [1:0] kind,
                              input int ts, input int data);
    check_output({tag, ".valid"}, 64'(rec_valid), 64'd1);
    check_output({tag, ".kind"},  64'(rec_kind),  64'(kind));
    check_output({tag, ".ts"},    64'(rec_ts),    64'(ts));
    check_output({tag, ".data"},  64'(rec_data),  64'(data));
    rec_ready = 1'b1;
    step();
    rec_ready = 1'b0;
  endtask

  task automatic wait_ts(input int n);
    int guard = 0;
    while (bts != n && guard < 500) begin
      step();
      guard++;
    end
    if (bts != n) begin
      checks++;
      failures++;
      $display("[TB] FAIL wait_ts: observed=%0d expected=%0d", bts, n);
    end
  endtask

  initial begin
    // Reset for three cycles; the open cycle afterwards has ts=0.
    repeat (3) step();
    reset = 1'b0;
    check_output("rst.valid",    64'(rec_valid), 64'd0);
    check_output("rst.overflow", 64'(overflow),  64'd0);
    check_output("rst.drop_cnt", 64'(drop_cnt),  64'd0);
    check_output("rst.kind",     64'(rec_kind),  64'd0);
    check_output("rst.ts",       64'(rec_ts),    64'd0);
    check_output("rst.data",     64'(rec_data),  64'd0);

    // Single transaction: START at 5, iterations at 7..10, DONE+continue at 12.
    wait_ts(5);
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    check_record("t1.start", K_START, 5, 0);
    iter_end = 1'b1;
    repeat (4) step();
    iter_end = 1'b0;
    wait_ts(12);
    ap_done = 1'b1;
    ap_continue = 1'b1;
    step();
    ap_done = 1'b0;
    ap_continue = 1'b0;
    check_record("t1.done", K_DONE, 12, 4);
    check_output("t1.no_stall", 64'(rec_valid), 64'd0);

    // Backpressured continue: DONE at 20, continue at 23; stalled cycles 20,21,22.
    wait_ts(15);
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    wait_ts(20);
    ap_done = 1'b1;
    step();
    ap_done = 1'b0;
    wait_ts(23);
    ap_continue = 1'b1;
    step();
    ap_continue = 1'b0;
    // Back in IDLE at 24: an immediate start is taken.
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    check_record("t2.start", K_START, 15, 1);
    check_record("t2.done",  K_DONE,  20, 0);
    check_record("t2.stall", K_STALL, 23, 3);
    check_record("t2.idle_start", K_START, 24, 2);

    // Finish in the DONE cycle: DONE at 30, FINISH deferred to 31, then stopped.
    wait_ts(30);
    ap_done = 1'b1;
    ap_continue = 1'b1;
    finish = 1'b1;
    step();
    ap_done = 1'b0;
    ap_continue = 1'b0;
    finish = 1'b0;
    step();
    ap_start = 1'b1;
    repeat (3) step();
    ap_start = 1'b0;
    check_record("t3.done",   K_DONE,   30, 0);
    check_record("t3.finish", K_FINISH, 31, 3);
    check_output("t3.stopped", 64'(rec_valid), 64'd0);

    // Overflow: 5 transactions with no consumer, 10 records into 8 slots.
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_output("t4.rst_valid", 64'(rec_valid), 64'd0);
    for (int i = 0; i < 5; i++) begin
      ap_start = 1'b1;
      step();
      ap_start = 1'b0;
      ap_done = 1'b1;
      ap_continue = 1'b1;
      step();
      ap_done = 1'b0;
      ap_continue = 1'b0;
    end
    check_output("t4.overflow", 64'(overflow), 64'd1);
    check_output("t4.drop_cnt", 64'(drop_cnt), 64'd2);
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) check_record("t4.start", K_START, k, k / 2);
      else            check_record("t4.done",  K_DONE,  k, 0);
    end
    check_output("t4.drained", 64'(rec_valid), 64'd0);

    // Full with a pop in the DONE cycle: fill to 8 while ACTIVE, then push+pop.
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    ap_done = 1'b1;
    step();
    ap_done = 1'b0;
    ap_continue = 1'b1;
    step();
    ap_continue = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ap_start = 1'b1;
      step();
      ap_start = 1'b0;
      ap_done = 1'b1;
      ap_continue = 1'b1;
      step();
      ap_done = 1'b0;
      ap_continue = 1'b0;
    end
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    check_output("t5.full_drop_cnt", 64'(drop_cnt), 64'd2);
    done_ts = bts;
    ap_done = 1'b1;
    ap_continue = 1'b1;
    rec_ready = 1'b1;
    step();
    ap_done = 1'b0;
    ap_continue = 1'b0;
    check_output("t5.drop_cnt", 64'(drop_cnt), 64'd2);
    check_output("t5.overflow", 64'(overflow), 64'd1);
    repeat (7) step();
    rec_ready = 1'b0;
    check_record("t5.done", K_DONE, done_ts, 0);
    check_output("t5.drained", 64'(rec_valid), 64'd0);

    // Reset while ACTIVE with 3 records queued.
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    ap_done = 1'b1;
    ap_continue = 1'b1;
    step();
    ap_done = 1'b0;
    ap_continue = 1'b0;
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    check_output("t6.queued", 64'(rec_valid), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_output("t6.valid",    64'(rec_valid), 64'd0);
    check_output("t6.overflow", 64'(overflow),  64'd0);
    check_output("t6.drop_cnt", 64'(drop_cnt),  64'd0);
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    check_record("t6.start", K_START, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
